// File: rtl/dm_responder.sv
// dm_responder: data-memory responder on the MEM-stage byte-enable data port.
// Serves combinational word reads and commits byte-masked writes on the rising
// edge. Instead of resetting the whole array, a sweep clears one word per
// cycle after reset is released, and dm_ready rises once the last word is done.
// Build option: define DM_TRACE_EN to build the registered store-commit trace.
// Without it the trace ports are still present and are tied to zero.
//
// state | meaning
// CLEAR | sweep writes 0 to word[sweep_cnt]; port reads 0, stores are ignored
// READY | normal service: combinational read, byte-masked write on the edge
module dm_responder #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        dm_ready,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic                  commit;

  // Address bits [1:0] never select anything: the port works on whole words.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, m_data_addr[1:0]};

  assign idx      = m_data_addr[ADDR_WIDTH+1:2];
  assign old_word = mem[idx];
  assign dm_ready = (state == READY);
  assign commit   = reset && (state == READY) && (m_data_byteen != 4'b0000);

  // Merge enabled lanes of the store data over the current word contents.
  always_comb begin
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (m_data_byteen[k]) merged[8*k +: 8] = m_data_wdata[8*k +: 8];
    end
  end

  // The read port is gated to 0 until the sweep has finished.
  always_comb begin
    m_data_rdata = 32'h0;
    if (state == READY) m_data_rdata = old_word;
  end

  // Clear sequencer: the sweep restarts from word 0 every time reset is released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
    end else if (state == CLEAR) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == {ADDR_WIDTH{1'b1}}) state <= READY;
    end
  end

  // Single array write port, shared by the sweep and by stores; nothing is written during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == CLEAR) mem[sweep_cnt] <= 32'h0;
      else if (commit)    mem[idx]       <= merged;
    end
  end

`ifdef DM_TRACE_EN
  // Commit trace: one-cycle valid pulse; the data fields hold between commits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= 32'h0;
      trace_addr  <= 32'h0;
      trace_data  <= 32'h0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        trace_pc   <= m_inst_addr;
        trace_addr <= {m_data_addr[31:2], 2'b00};
        trace_data <= merged;
      end
    end
  end
`else
  // Without the trace option the upper address bits and the PC feed nothing.
  logic unused_trace_inputs;
  assign unused_trace_inputs = &{1'b0, m_data_addr[31:ADDR_WIDTH+2], m_inst_addr};

  assign trace_valid = 1'b0;
  assign trace_pc    = 32'h0;
  assign trace_addr  = 32'h0;
  assign trace_data  = 32'h0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed testbench for dm_responder (default depth 4096).
// Trace expectations follow DM_TRACE_EN in the same way as the design.
module tb_dm_responder;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        dm_ready;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  int checks   = 0;
  int failures = 0;

  dm_responder #(.ADDR_WIDTH(12)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .dm_ready      (dm_ready),
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .trace_addr    (trace_addr),
    .trace_data    (trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one active edge; inputs change and outputs are sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // count edges until dm_ready, bounded
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!dm_ready && cnt < 5000) begin
      step();
      cnt++;
    end
  endtask

  // present a read address and let combinational logic settle
  task automatic set_read(input logic [31:0] a);
    m_data_addr   = a;
    m_data_byteen = 4'b0000;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; m_data_addr = 32'h0; m_data_wdata = 32'h0;
    m_data_byteen = 4'b0000; m_inst_addr = 32'h0;
    repeat (3) step();
    checks++; if (dm_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b want=0", dm_ready); end
    checks++; if (m_data_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", m_data_rdata); end
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%0b want=0", trace_valid); end
    checks++; if ({trace_pc, trace_addr, trace_data} !== 96'h0) begin failures++;
      $display("FAIL reset_tfields got=%h/%h/%h want=0", trace_pc, trace_addr, trace_data); end
  endtask

  task automatic test_clear();
    int cnt;
    reset = 1'b1;
    wait_ready(cnt);
    checks++; if (cnt !== 4096) begin failures++; $display("FAIL clear_latency got=%0d want=4096", cnt); end
    set_read(32'h0);
    checks++; if (m_data_rdata !== 32'h0) begin failures++; $display("FAIL clear_rd0 got=%h want=0", m_data_rdata); end
    set_read(32'h3FFC);
    checks++; if (m_data_rdata !== 32'h0) begin failures++; $display("FAIL clear_rd3ffc got=%h want=0", m_data_rdata); end
  endtask

  task automatic test_store_word();
    m_data_addr = 32'h10; m_data_wdata = 32'h12345678; m_data_byteen = 4'b1111; m_inst_addr = 32'h3004;
    step();
    set_read(32'h10);
    checks++; if (m_data_rdata !== 32'h12345678) begin failures++; $display("FAIL sw_rdata got=%h want=12345678", m_data_rdata); end
`ifdef DM_TRACE_EN
    checks++; if ({trace_valid, trace_pc, trace_addr, trace_data} !== {1'b1, 32'h3004, 32'h10, 32'h12345678}) begin failures++;
      $display("FAIL sw_trace got=%0b/%h/%h/%h want=1/3004/10/12345678", trace_valid, trace_pc, trace_addr, trace_data); end
    step();
    checks++; if ({trace_valid, trace_pc, trace_data} !== {1'b0, 32'h3004, 32'h12345678}) begin failures++;
      $display("FAIL sw_trace_hold got=%0b/%h/%h want=0/3004/12345678", trace_valid, trace_pc, trace_data); end
`else
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL sw_tvalid got=%0b want=0", trace_valid); end
`endif
  endtask

  task automatic test_back_to_back();
    // sb then sh on consecutive edges to the same word
    m_data_addr = 32'h11; m_data_wdata = 32'h0000AB00; m_data_byteen = 4'b0010; m_inst_addr = 32'h3008;
    step();
    checks++; if (m_data_rdata !== 32'h1234AB78) begin failures++; $display("FAIL sb_rdata got=%h want=1234ab78", m_data_rdata); end
`ifdef DM_TRACE_EN
    checks++; if ({trace_valid, trace_addr, trace_data} !== {1'b1, 32'h10, 32'h1234AB78}) begin failures++;
      $display("FAIL sb_trace got=%0b/%h/%h want=1/10/1234ab78", trace_valid, trace_addr, trace_data); end
`endif
    m_data_addr = 32'h12; m_data_wdata = 32'hBEEF0000; m_data_byteen = 4'b1100; m_inst_addr = 32'h300C;
    step();
    set_read(32'h10);
    checks++; if (m_data_rdata !== 32'hBEEFAB78) begin failures++; $display("FAIL sh_rdata got=%h want=beefab78", m_data_rdata); end
`ifdef DM_TRACE_EN
    checks++; if ({trace_valid, trace_pc, trace_addr, trace_data} !== {1'b1, 32'h300C, 32'h10, 32'hBEEFAB78}) begin failures++;
      $display("FAIL sh_trace got=%0b/%h/%h/%h want=1/300c/10/beefab78", trace_valid, trace_pc, trace_addr, trace_data); end
`else
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL sh_tvalid got=%0b want=0", trace_valid); end
`endif
  endtask

  task automatic test_alias();
    m_data_addr = 32'h4010; m_data_wdata = 32'hCAFEF00D; m_data_byteen = 4'b1111; m_inst_addr = 32'h3010;
    step();
    set_read(32'h10);
    checks++; if (m_data_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL alias_rdata got=%h want=cafef00d", m_data_rdata); end
`ifdef DM_TRACE_EN
    checks++; if (trace_addr !== 32'h4010) begin failures++; $display("FAIL alias_taddr got=%h want=4010", trace_addr); end
`endif
    m_data_addr = 32'h13; m_data_wdata = 32'h55AA55AA; m_data_byteen = 4'b1111;
    step();
    set_read(32'h10);
    checks++; if (m_data_rdata !== 32'h55AA55AA) begin failures++; $display("FAIL offset_rdata got=%h want=55aa55aa", m_data_rdata); end
`ifdef DM_TRACE_EN
    checks++; if (trace_addr !== 32'h10) begin failures++; $display("FAIL offset_taddr got=%h want=10", trace_addr); end
`endif
    set_read(32'h14);
    checks++; if (m_data_rdata !== 32'h0) begin failures++; $display("FAIL neighbour_rdata got=%h want=0", m_data_rdata); end
  endtask

  task automatic test_same_cycle_rw();
    m_data_addr = 32'h20; m_data_wdata = 32'hFFFFFFFF; m_data_byteen = 4'b1111;
    #1;
    checks++; if (m_data_rdata !== 32'h0) begin failures++; $display("FAIL rw_pre got=%h want=0", m_data_rdata); end
    step();
    set_read(32'h20);
    checks++; if (m_data_rdata !== 32'hFFFFFFFF) begin failures++; $display("FAIL rw_post got=%h want=ffffffff", m_data_rdata); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    // store commits, then reset on the next edge must kill the trace pulse
    m_data_addr = 32'h40; m_data_wdata = 32'h11112222; m_data_byteen = 4'b1111; m_inst_addr = 32'h3020;
    step();
    reset = 1'b0;
    step();
    checks++; if ({dm_ready, trace_valid} !== 2'b00) begin failures++;
      $display("FAIL midop_reset got=ready%0b/tv%0b want=0/0", dm_ready, trace_valid); end
    checks++; if (m_data_rdata !== 32'h0) begin failures++; $display("FAIL midop_rdata got=%h want=0", m_data_rdata); end
    m_data_byteen = 4'b0000;
    reset = 1'b1;
    repeat (100) step();
    // reset for 2 edges mid-sweep, with a store presented
    reset = 1'b0; m_data_addr = 32'h30; m_data_wdata = 32'h99998888; m_data_byteen = 4'b1111;
    repeat (2) step();
    reset = 1'b1; m_data_byteen = 4'b0000;
    repeat (200) step();
    // store during CLEAR, after its word has already been swept
    m_data_addr = 32'h30; m_data_wdata = 32'hDEADBEEF; m_data_byteen = 4'b1111; m_inst_addr = 32'h3030;
    step();
    m_data_byteen = 4'b0000;
    checks++; if ({dm_ready, trace_valid, m_data_rdata} !== 34'h0) begin failures++;
      $display("FAIL clear_store got=ready%0b/tv%0b/%h want=0/0/0", dm_ready, trace_valid, m_data_rdata); end
    wait_ready(cnt);
    checks++; if (cnt + 201 !== 4096) begin failures++; $display("FAIL rerelease_latency got=%0d want=4096", cnt + 201); end
    set_read(32'h30);
    checks++; if (m_data_rdata !== 32'h0) begin failures++; $display("FAIL clear_store_rd got=%h want=0", m_data_rdata); end
    set_read(32'h20);
    checks++; if (m_data_rdata !== 32'h0) begin failures++; $display("FAIL reswept_rd got=%h want=0", m_data_rdata); end
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL final_tvalid got=%0b want=0", trace_valid); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_store_word();
    test_back_to_back();
    test_alias();
    test_same_cycle_rw();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Synthesizable data-memory responder on the core's byte-enable data port: the slave end of the `m_data_*` interface the pipeline's MEM stage drives. It serves combinational word reads and commits byte-masked writes on the clock edge. A one-word-per-cycle clear sequencer replaces bulk array reset. An optional registered commit trace lets the bench print store records without probing the array.

## Interface

Parameters:
- `ADDR_WIDTH`, 12: word-address bits; depth = 2^ADDR_WIDTH words (default 4096).

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low; the block is in reset while `reset`==0.
- `m_data_addr`  in  32: byte address from MEM stage.
- `m_data_wdata`  in  32: store data, already lane-aligned by the initiator.
- `m_data_byteen`  in  4: byte write enables; 0000 = no write.
- `m_inst_addr`  in  32: PC of the MEM-stage instruction, used only for trace.
- `m_data_rdata`  out  32: read word.
- `dm_ready`  out  1: array cleared and accepting accesses.
- `trace_valid`  out  1: commit record valid (DM_TRACE_EN only).
- `trace_pc`  out  32: PC of committed store (DM_TRACE_EN only).
- `trace_addr`  out  32: word-aligned byte address of commit (DM_TRACE_EN only).
- `trace_data`  out  32: full merged word written (DM_TRACE_EN only).

## Operation

- Word index = `m_data_addr[ADDR_WIDTH+1:2]`. Bits [1:0] are ignored. Bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo 4·depth.
- Two states, CLEAR and READY.
  - While `reset`==0: state forced to CLEAR, sweep counter forced to 0.
  - CLEAR, `reset`==1: write 0 to word[counter], then increment. When counter == depth-1, that word is cleared and state goes to READY on the same edge.
  - READY: normal service. Stays there until `reset`==0.
- In CLEAR, `dm_ready`=0, `m_data_rdata`=0, byteen ignored (no write, no trace).
- In READY:
  - `m_data_rdata` = word[index], combinational.
  - If byteen≠0, on the rising edge: word[index] lane k ← wdata lane k for each byteen[k]=1; other lanes keep their old value.
- Merged word = old word with enabled lanes replaced, computed combinationally from the current array contents.
- Trace record, registered on the commit edge:
  - `trace_valid`=1 for exactly one cycle.
  - `trace_pc` = `m_inst_addr`.
  - `trace_addr` = `m_data_addr` & 32'hFFFF_FFFC.
  - `trace_data` = merged word.
  - In cycles with no commit, `trace_valid`=0 and the other trace fields hold their last values.

## Timing

- Reset values: `dm_ready`=0, `m_data_rdata`=0, `trace_valid`=0, `trace_pc`/`trace_addr`/`trace_data`=0, counter=0.
- Clear latency: `dm_ready` rises exactly depth cycles after the first edge sampling `reset`==1 (4096 for default).
- Read latency 0: `m_data_rdata` follows the address in the same cycle.
- Read and write to the same word in one cycle: `rdata` returns the pre-write value; the new value is visible the cycle after the edge.
- Back-to-back stores to the same word: the second merge uses the first's committed value, with no hazard.
- Trace appears in the cycle following the commit edge.
- `reset` driven low mid-sweep or mid-operation:
  - On that edge: state returns to CLEAR, counter returns to 0, `trace_valid`=0.
  - Any write presented on that edge is dropped.
  - The sweep restarts from word 0 after release.

## Configuration

- `DM_TRACE_EN` defined: trace ports and registers exist as above.
- `DM_TRACE_EN` undefined:
  - Trace ports are still present, tied to 0 (`trace_valid`=0 permanently).
  - Trace registers are not built.
  - Memory behaviour is identical.

## Test plan

- Release reset, byteen=0: `dm_ready`=0 for exactly 4096 cycles then 1; reads of 0x0, 0x3FFC return 0.
- Store: addr=0x10, byteen=1111, wdata=0x12345678, pc=0x3004. Next cycle: rdata@0x10=0x12345678. With DM_TRACE_EN: trace_valid=1, pc=0x3004, addr=0x10, data=0x12345678.
- Then sb: addr=0x11, byteen=0010, wdata=0x0000AB00 → word 0x1234AB78. Then sh: addr=0x12, byteen=1100, wdata=0xBEEF0000 → 0xBEEFAB78.
- Aliasing and offsets: store 0xCAFEF00D to 0x4010 (depth 4096) → read 0x10 returns 0xCAFEF00D; trace_addr=0x4010. Store to 0x13 commits to word 0x10.
- Same-cycle read and write to 0x20 with 0xFFFFFFFF over old 0: rdata=0 that cycle, 0xFFFFFFFF next cycle.
- Reset low at sweep cycle 100 for 2 cycles: `dm_ready` rises 4096 cycles after re-release. A store attempted during CLEAR has no effect and no trace. Without DM_TRACE_EN, trace_valid stays 0 throughout all scenarios.
